// File: rtl/io_bus_arbiter_if.sv
// IO_bus register-bus signals shared by the arbiter (master) and the slave units.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_reg_address;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_handshake1_1;
  logic              bus_handshake1_2;
  logic [DATA_W-1:0] bus_data_in;

  modport master (
    output bus_rw, bus_reg_address, bus_data_out, bus_handshake1_1,
    input  bus_handshake1_2, bus_data_in
  );

  modport slave (
    input  bus_rw, bus_reg_address, bus_data_out, bus_handshake1_1,
    output bus_handshake1_2, bus_data_in
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin two-requester arbiter running the four-phase IO_bus handshake.
// Optional handshake timeout is enabled by defining IO_ARB_TIMEOUT_EN.
module io_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_rw,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  io_bus_arbiter_if.master  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STROBE  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic              rw_q, rw_d;
  logic              strobe_q, strobe_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win_s;
  logic              timeout_s;

`ifdef IO_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;

  // Wait counter: zero on every state change, counts cycles spent waiting.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_STROBE || state_q == ST_RELEASE) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign timeout_s = (cnt_q == TMO_LAST);

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout_s;
  assign unused_timeout_s = 8'(TIMEOUT);
  assign timeout_s        = 1'b0;
`endif

  // Winner: a lone requester wins, otherwise whoever was not served last.
  always_comb begin
    if (req == 2'b11) begin
      win_s = ~last_q;
    end else begin
      win_s = req[1];
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = 2'b00;
    err_d    = 1'b0;
    rw_d     = rw_q;
    strobe_d = strobe_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          last_d   = win_s;
          rw_d     = req_rw[win_s];
          strobe_d = 1'b1;
          state_d  = ST_STROBE;
          if (win_s) begin
            grant_d = 2'b10;
            addr_d  = req_addr1;
            wdata_d = req_wdata1;
          end else begin
            grant_d = 2'b01;
            addr_d  = req_addr0;
            wdata_d = req_wdata0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (bus.bus_handshake1_2) begin
          strobe_d = 1'b0;
          state_d  = ST_RELEASE;
          if (!rw_q) begin
            rbuf_d = bus.bus_data_in;
          end else begin
            rbuf_d = rbuf_q;
          end
        end else if (timeout_s) begin
          strobe_d = 1'b0;
          grant_d  = 2'b00;
          done_d   = grant_q;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_RELEASE: begin
        // Read data reaches rdata only together with a successful done.
        if (!bus.bus_handshake1_2) begin
          grant_d = 2'b00;
          done_d  = grant_q;
          state_d = ST_DONE;
          if (!rw_q) begin
            rdata_d = rbuf_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          grant_d = 2'b00;
          done_d  = grant_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = 2'b00;
        strobe_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      rw_q     <= 1'b0;
      strobe_q <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rw_q     <= rw_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign grant                = grant_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign rdata                = rdata_q;
  assign bus.bus_rw           = rw_q;
  assign bus.bus_reg_address  = addr_q;
  assign bus.bus_data_out     = wdata_q;
  assign bus.bus_handshake1_1 = strobe_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: table of single transactions plus
// hand-written reset, contention, early-ack, timeout and abort sequences.
module tb_io_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, req_rw;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] w0, w1;
  logic [1:0]    grant, done;
  logic          err;
  logic [DW-1:0] rdata;

  io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
    .req_addr0(a0), .req_addr1(a1), .req_wdata0(w0), .req_wdata1(w1),
    .grant(grant), .done(done), .err(err), .rdata(rdata), .bus(bif)
  );

  always #5 clk = ~clk;

  // Slave model: ack rises ack_dly edges after it sees the strobe,
  // falls rel_dly edges after it sees the strobe drop.
  logic          slave_ack = 1'b0;
  int            wait_cnt = 0;
  int            ack_dly = 1;
  int            rel_dly = 1;
  logic          ack_en = 1'b1;
  logic          ack_force = 1'b0;
  logic [DW-1:0] sl_data = '0;

  always @(posedge clk) begin
    if (bif.bus_handshake1_1 && !slave_ack) begin
      if (wait_cnt + 1 >= ack_dly) begin
        slave_ack <= 1'b1;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else if (!bif.bus_handshake1_1 && slave_ack) begin
      if (wait_cnt + 1 >= rel_dly) begin
        slave_ack <= 1'b0;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  assign bif.bus_handshake1_2 = (slave_ack & ack_en) | ack_force;
  assign bif.bus_data_in      = sl_data;

  int            tests = 0;
  int            errors = 0;
  logic [DW-1:0] cur_rd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One transaction from requester rq; sdown/donek are cycles after the req edge.
  task automatic run_txn(input string nm, input logic rq, input logic rw,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input int sdown, input int donek,
                         input logic [31:0] erd, input logic eerr);
    logic [1:0] g;
    logic       stable;
    int         got_k;
    g      = rq ? 2'b10 : 2'b01;
    stable = 1'b1;
    got_k  = 0;
    @(posedge clk); #1;
    req    = g;
    req_rw = {rw, rw};
    if (rq) begin a1 = addr; w1 = wdata; end
    else    begin a0 = addr; w0 = wdata; end
    for (int k = 1; k <= 60 && got_k == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) check({nm, " grant"}, 64'(grant), 64'(g));
      if (done != 2'b00) begin
        got_k = k;
        check({nm, " done cycle"}, 64'(k), 64'(donek));
        check({nm, " done owner"}, 64'(done), 64'(g));
        check({nm, " err"}, 64'(err), 64'(eerr));
        check({nm, " rdata"}, 64'(rdata), 64'(erd));
        check({nm, " grant at done"}, 64'(grant), 64'd0);
        check({nm, " strobe at done"}, 64'(bif.bus_handshake1_1), 64'd0);
        req = 2'b00;
      end else if (grant !== g || bif.bus_rw !== rw || bif.bus_reg_address !== addr ||
                   bif.bus_data_out !== wdata || rdata !== cur_rd ||
                   bif.bus_handshake1_1 !== (k < sdown)) begin
        stable = 1'b0;
      end
    end
    if (got_k == 0) begin
      check({nm, " done cycle"}, 64'(got_k), 64'(donek));
      req = 2'b00;
    end
    check({nm, " bus stable"}, 64'(stable), 64'd1);
    @(posedge clk); #1;
    check({nm, " done one-shot"}, 64'(done), 64'd0);
    cur_rd = erd;
  endtask

  typedef struct {
    logic        rq;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          ackd;
    int          reld;
    int          sdown;
    int          donek;
    logic [31:0] erd;
  } vec_t;

  vec_t       vt [6];
  logic [1:0] exp_g [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         ng, nd;
    logic [1:0] prev_g;

    vt[0] = '{1'b0, 1'b0, 8'h05, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1, 3,  5, 32'hDEAD_BEEF};
    vt[1] = '{1'b1, 1'b0, 8'hA0, 32'h0000_0000, 32'hCAFE_F00D, 1, 1, 3,  5, 32'hCAFE_F00D};
    vt[2] = '{1'b0, 1'b1, 8'h11, 32'hA5A5_5A5A, 32'h1111_1111, 2, 1, 4,  6, 32'hCAFE_F00D};
    vt[3] = '{1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h2222_2222, 1, 2, 3,  6, 32'hCAFE_F00D};
    vt[4] = '{1'b0, 1'b0, 8'h00, 32'h0000_0000, 32'h0BAD_F00D, 7, 3, 9, 13, 32'h0BAD_F00D};
    vt[5] = '{1'b1, 1'b0, 8'h7F, 32'h0000_0000, 32'h0000_0001, 3, 4, 5, 10, 32'h0000_0001};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset held with both requesting: everything stays at reset values.
    reset = 1'b1; req = 2'b11; req_rw = 2'b10;
    a0 = 8'h05; w0 = 32'h0; a1 = 8'h02; w1 = 32'h1234_5678;
    sl_data = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #1;
    check("reset grant", 64'(grant), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    check("reset bus_rw", 64'(bif.bus_rw), 64'd0);
    check("reset addr", 64'(bif.bus_reg_address), 64'd0);
    check("reset data_out", 64'(bif.bus_data_out), 64'd0);
    check("reset strobe", 64'(bif.bus_handshake1_1), 64'd0);
    reset = 1'b0;

    // Contention: both held, grants alternate starting with requester 0.
    ng = 0; nd = 0; prev_g = 2'b00;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (ng < 4) check($sformatf("rr grant %0d", ng), 64'(grant), 64'(exp_g[ng]));
        if (grant == 2'b10) begin
          check("rr req1 data_out", 64'(bif.bus_data_out), 64'h1234_5678);
          check("rr req1 addr", 64'(bif.bus_reg_address), 64'h02);
          check("rr req1 rw", 64'(bif.bus_rw), 64'd1);
        end
        ng++;
      end
      if (done != 2'b00) begin
        if (nd < 4) check($sformatf("rr done %0d", nd), 64'(done), 64'(exp_g[nd]));
        check("rr err", 64'(err), 64'd0);
        if (done == 2'b01) check("rr req0 rdata", 64'(rdata), 64'h5555_AAAA);
        nd++;
      end
      prev_g = grant;
    end
    req = 2'b00;
    check("rr grant count", 64'(ng), 64'd4);
    check("rr done count", 64'(nd), 64'd4);
    cur_rd = 32'h5555_AAAA;
    @(posedge clk); #1;

    // Table of single transactions, including the slow slave.
    for (int i = 0; i < 6; i++) begin
      ack_dly = vt[i].ackd;
      rel_dly = vt[i].reld;
      sl_data = vt[i].sdata;
      run_txn($sformatf("vec%0d", i), vt[i].rq, vt[i].rw, vt[i].addr, vt[i].wdata,
              vt[i].sdown, vt[i].donek, vt[i].erd, 1'b0);
    end
    ack_dly = 1;
    rel_dly = 1;

    // Ack already high when the strobe goes up: accepted on the first STROBE cycle.
    ack_en = 1'b0; ack_force = 1'b1; sl_data = 32'h600D_0001;
    @(posedge clk); #1;
    req = 2'b01; req_rw = 2'b00; a0 = 8'h33; w0 = 32'h0;
    @(posedge clk); #1;
    check("early ack grant", 64'(grant), 64'h1);
    check("early ack strobe up", 64'(bif.bus_handshake1_1), 64'd1);
    @(posedge clk); #1;
    check("early ack strobe down", 64'(bif.bus_handshake1_1), 64'd0);
    ack_force = 1'b0;
    @(posedge clk); #1;
    check("early ack done", 64'(done), 64'h1);
    check("early ack rdata", 64'(rdata), 64'h600D_0001);
    req = 2'b00;
    cur_rd = 32'h600D_0001;
    repeat (4) @(posedge clk);
    #1;
    ack_en = 1'b1;

`ifdef IO_ARB_TIMEOUT_EN
    // Slave never acks: strobe drops after 10 STROBE cycles, done with err.
    ack_en = 1'b0; sl_data = 32'h9999_9999;
    run_txn("timeout", 1'b1, 1'b0, 8'h44, 32'h0, 11, 11, cur_rd, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    ack_en = 1'b1; sl_data = 32'h2468_ACE0;
    run_txn("after timeout", 1'b1, 1'b0, 8'h45, 32'h0, 3, 5, 32'h2468_ACE0, 1'b0);
`endif

    // Reset while waiting in RELEASE: transaction aborted, no done.
    rel_dly = 6; sl_data = 32'h7777_0000;
    @(posedge clk); #1;
    req = 2'b01; req_rw = 2'b00; a0 = 8'h21; w0 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("abort in release", 64'({grant, bif.bus_handshake1_1}), 64'b010);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort strobe", 64'(bif.bus_handshake1_1), 64'd0);
    check("abort grant", 64'(grant), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort rdata", 64'(rdata), 64'd0);
    check("abort addr", 64'(bif.bus_reg_address), 64'd0);
    req = 2'b00; reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done != 2'b00) nd++;
    end
    check("abort no done", 64'(nd), 64'd0);
    rel_dly = 1; cur_rd = 32'h0; sl_data = 32'h1357_9BDF;
    run_txn("post abort", 1'b0, 1'b0, 8'h22, 32'h0, 3, 5, 32'h1357_9BDF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
